user_tx_arbiter: RTL and testbench

USER_TX_ARBITER -- requirements
Module: user_tx_arbiter

---
 rtl/user_pkg.sv | 25 ++
 rtl/user_tx_arbiter_if.sv | 41 ++++
 rtl/user_tag_table.sv | 89 ++++++++
 rtl/user_tx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_user_tx_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/user_pkg.sv
// Shared types for the user TX arbiter: FSM state, the "no tag" marker for
// posted writes, and the per-slot record held by the tag table.
package user_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_e;

   localparam logic [7:0] TAG_NONE = 8'hFF;
   localparam int         OWNER_W  = 2;
   localparam int         TIMER_W  = 32;

   typedef struct packed {
      logic               valid;
      logic [OWNER_W-1:0] owner;
      logic [TIMER_W-1:0] timer;
   } slot_t;

   function automatic logic [3:0] owner_onehot(input logic [OWNER_W-1:0] idx);
      owner_onehot = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/user_tx_arbiter_if.sv
// Request, encoder, decoder and completion signals of the user TX arbiter.
// The arbiter uses the slave modport; the requester/encoder side uses master.
interface user_tx_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_is_read;
   logic [3*NUM_REQ-1:0]  req_type;
   logic [64*NUM_REQ-1:0] req_addr;
   logic [32*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic [2:0]            tx_type;
   logic [7:0]            tx_tag;
   logic [63:0]           tx_addr;
   logic [31:0]           tx_data;
   logic                  tx_start;
   logic                  tx_done;
   logic [7:0]            rx_tag;
   logic [31:0]           rx_data;
   logic                  rx_good;
   logic                  rx_bad;
   logic [NUM_REQ-1:0]    cpl_valid;
   logic [31:0]           cpl_data;
   logic                  cpl_err;
   logic                  stray_cpl;
   logic                  busy;

   modport slave (
      input  req_valid, req_is_read, req_type, req_addr, req_data,
      input  tx_done, rx_tag, rx_data, rx_good, rx_bad,
      output req_ready, tx_type, tx_tag, tx_addr, tx_data, tx_start,
      output cpl_valid, cpl_data, cpl_err, stray_cpl, busy
   );

   modport master (
      output req_valid, req_is_read, req_type, req_addr, req_data,
      output tx_done, rx_tag, rx_data, rx_good, rx_bad,
      input  req_ready, tx_type, tx_tag, tx_addr, tx_data, tx_start,
      input  cpl_valid, cpl_data, cpl_err, stray_cpl, busy
   );
endinterface

// File: rtl/user_tag_table.sv
// Outstanding-read tag table: lowest-free allocation, lookup/free on completion
// and, when USER_TX_ARB_TIMEOUT_EN is defined, per-slot completion timeout.
module user_tag_table
   import user_pkg::*;
#(
   parameter  int MAX_OUTST   = 4,
   parameter  int CPL_TIMEOUT = 65535,
   localparam int IW          = $clog2(MAX_OUTST)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               alloc,
   input  logic [OWNER_W-1:0] alloc_owner,
   output logic               free_avail,
   output logic [IW-1:0]      free_idx,
   input  logic               lookup_en,
   input  logic [7:0]         lookup_tag,
   output logic               hit,
   output logic [OWNER_W-1:0] hit_owner,
   output logic               to_fire,
   output logic [OWNER_W-1:0] to_owner,
   output logic               any_valid
);

   slot_t         slot_q [MAX_OUTST];
   slot_t         slot_d [MAX_OUTST];
   logic [IW-1:0] lk_idx_s;
   logic [IW-1:0] to_idx_s;

   // Free search, completion lookup, timeout selection and next slot state.
   always_comb begin
      free_avail = 1'b0;
      free_idx   = '0;
      any_valid  = 1'b0;
      to_fire    = 1'b0;
      to_idx_s   = '0;
      for (int i = MAX_OUTST - 1; i >= 0; i--) begin
         free_idx   = !slot_q[i].valid ? IW'(i) : free_idx;
         free_avail = free_avail | !slot_q[i].valid;
         any_valid  = any_valid | slot_q[i].valid;
      end
      lk_idx_s  = lookup_tag[IW-1:0];
      hit       = lookup_en && (lookup_tag < 8'(MAX_OUTST)) && slot_q[lk_idx_s].valid;
      hit_owner = slot_q[lk_idx_s].owner;
      for (int i = 0; i < MAX_OUTST; i++) begin
         slot_d[i] = slot_q[i];
      end
`ifdef USER_TX_ARB_TIMEOUT_EN
      // Any decoder result this cycle owns the completion bus; expiry waits.
      for (int i = MAX_OUTST - 1; i >= 0; i--) begin
         if (slot_q[i].valid && (slot_q[i].timer >= TIMER_W'(CPL_TIMEOUT)) && !lookup_en) begin
            to_fire  = 1'b1;
            to_idx_s = IW'(i);
         end else begin
            to_idx_s = to_idx_s;
         end
         slot_d[i].timer = (slot_q[i].valid && (slot_q[i].timer != '1)) ?
                           slot_q[i].timer + 32'd1 : slot_q[i].timer;
      end
`endif
      to_owner = slot_q[to_idx_s].owner;
      if (hit) begin
         slot_d[lk_idx_s] = '0;
      end else if (to_fire) begin
         slot_d[to_idx_s] = '0;
      end else begin
         slot_d[lk_idx_s] = slot_d[lk_idx_s];
      end
      if (alloc) begin
         slot_d[free_idx] = '{valid: 1'b1, owner: alloc_owner, timer: '0};
      end else begin
         slot_d[free_idx] = slot_d[free_idx];
      end
   end

   // Slot storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_OUTST; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < MAX_OUTST; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

endmodule

// File: rtl/user_tx_arbiter.sv
// Round-robin arbiter sharing one TLP encoder among NUM_REQ requesters, with
// read tag tracking and completion routing. Optional: USER_TX_ARB_TIMEOUT_EN.
module user_tx_arbiter
   import user_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int MAX_OUTST   = 4,
   parameter int CPL_TIMEOUT = 65535
) (
   input  logic             user_clk,
   input  logic             reset_n,
   user_tx_arbiter_if.slave bus
);

   localparam int IW = $clog2(MAX_OUTST);
   localparam int RW = $clog2(NUM_REQ);

   state_e             state_q, state_d;
   logic [RW-1:0]      rr_q, rr_d;
   logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
   logic [2:0]         tx_type_q, tx_type_d;
   logic [7:0]         tx_tag_q, tx_tag_d;
   logic [63:0]        tx_addr_q, tx_addr_d;
   logic [31:0]        tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;
   logic [NUM_REQ-1:0] cpl_valid_q, cpl_valid_d;
   logic [31:0]        cpl_data_q, cpl_data_d;
   logic               cpl_err_q, cpl_err_d;
   logic               stray_q, stray_d;

   logic [NUM_REQ-1:0] eligible_s;
   logic               grant_found_s;
   logic [RW-1:0]      grant_idx_s;
   logic [RW-1:0]      cand_s;
   logic               alloc_s;
   logic               free_avail_s;
   logic [IW-1:0]      free_idx_s;
   logic               lookup_en_s;
   logic               hit_s;
   logic [OWNER_W-1:0] hit_owner_s;
   logic               to_fire_s;
   logic [OWNER_W-1:0] to_owner_s;
   logic               any_valid_s;

   user_tag_table #(
      .MAX_OUTST   (MAX_OUTST),
      .CPL_TIMEOUT (CPL_TIMEOUT)
   ) u_tags (
      .clk         (user_clk),
      .rst_n       (reset_n),
      .alloc       (alloc_s),
      .alloc_owner (OWNER_W'(grant_idx_s)),
      .free_avail  (free_avail_s),
      .free_idx    (free_idx_s),
      .lookup_en   (lookup_en_s),
      .lookup_tag  (bus.rx_tag),
      .hit         (hit_s),
      .hit_owner   (hit_owner_s),
      .to_fire     (to_fire_s),
      .to_owner    (to_owner_s),
      .any_valid   (any_valid_s)
   );

   // Round-robin pick: first eligible requester at or after the pointer.
   always_comb begin
      eligible_s    = bus.req_valid & (~bus.req_is_read | {NUM_REQ{free_avail_s}});
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      cand_s        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_s = RW'((int'(rr_q) + k) % NUM_REQ);
         if (!grant_found_s && eligible_s[cand_s]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_s;
         end else begin
            grant_idx_s = grant_idx_s;
         end
      end
   end

   // Next-state for the transfer FSM, encoder outputs and completion routing.
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      req_ready_d = '0;
      tx_start_d  = 1'b0;
      tx_type_d   = tx_type_q;
      tx_tag_d    = tx_tag_q;
      tx_addr_d   = tx_addr_q;
      tx_data_d   = tx_data_q;
      alloc_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_found_s) begin
               state_d     = ST_SEND;
               rr_d        = (grant_idx_s == RW'(NUM_REQ - 1)) ? '0 : grant_idx_s + RW'(1);
               req_ready_d = NUM_REQ'(owner_onehot(OWNER_W'(grant_idx_s)));
               tx_start_d  = 1'b1;
               tx_type_d   = bus.req_type[3*int'(grant_idx_s) +: 3];
               tx_addr_d   = bus.req_addr[64*int'(grant_idx_s) +: 64];
               tx_data_d   = bus.req_data[32*int'(grant_idx_s) +: 32];
               tx_tag_d    = bus.req_is_read[grant_idx_s] ? 8'(free_idx_s) : TAG_NONE;
               alloc_s     = bus.req_is_read[grant_idx_s];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND:      state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: state_d = bus.tx_done ? ST_IDLE : ST_WAIT_DONE;
         default:      state_d = ST_IDLE;
      endcase

      lookup_en_s = bus.rx_good | bus.rx_bad;
      cpl_valid_d = '0;
      cpl_data_d  = cpl_data_q;
      cpl_err_d   = 1'b0;
      stray_d     = 1'b0;
      if (lookup_en_s && hit_s) begin
         cpl_valid_d = NUM_REQ'(owner_onehot(hit_owner_s));
         cpl_data_d  = bus.rx_data;
         cpl_err_d   = bus.rx_bad;
      end else if (lookup_en_s) begin
         stray_d = 1'b1;
      end else if (to_fire_s) begin
         cpl_valid_d = NUM_REQ'(owner_onehot(to_owner_s));
         cpl_data_d  = 32'd0;
         cpl_err_d   = 1'b1;
      end else begin
         stray_d = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge user_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         rr_q        <= '0;
         req_ready_q <= '0;
         tx_type_q   <= 3'd0;
         tx_tag_q    <= 8'd0;
         tx_addr_q   <= 64'd0;
         tx_data_q   <= 32'd0;
         tx_start_q  <= 1'b0;
         cpl_valid_q <= '0;
         cpl_data_q  <= 32'd0;
         cpl_err_q   <= 1'b0;
         stray_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         req_ready_q <= req_ready_d;
         tx_type_q   <= tx_type_d;
         tx_tag_q    <= tx_tag_d;
         tx_addr_q   <= tx_addr_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         cpl_valid_q <= cpl_valid_d;
         cpl_data_q  <= cpl_data_d;
         cpl_err_q   <= cpl_err_d;
         stray_q     <= stray_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.tx_type   = tx_type_q;
   assign bus.tx_tag    = tx_tag_q;
   assign bus.tx_addr   = tx_addr_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.tx_start  = tx_start_q;
   assign bus.cpl_valid = cpl_valid_q;
   assign bus.cpl_data  = cpl_data_q;
   assign bus.cpl_err   = cpl_err_q;
   assign bus.stray_cpl = stray_q;
   assign bus.busy      = (state_q != ST_IDLE) | any_valid_s;

endmodule

// File: tb/tb_user_tx_arbiter.sv
// Scoreboard bench for user_tx_arbiter: a queue-based reference model predicts
// grants, tags and completions; a negedge monitor pops and compares.
module tb_user_tx_arbiter;

   localparam int NR = 3;
   localparam int MO = 4;
   localparam int CT = 100;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   user_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

   user_tx_arbiter #(
      .NUM_REQ     (NR),
      .MAX_OUTST   (MO),
      .CPL_TIMEOUT (CT)
   ) dut (
      .user_clk (clk),
      .reset_n  (rst_n),
      .bus      (bus)
   );

   typedef struct {
      int          who;
      logic [2:0]  typ;
      logic [7:0]  tag;
      logic [63:0] addr;
      logic [31:0] data;
   } tx_exp_t;

   typedef struct {
      int          who;
      logic [31:0] data;
      logic        err;
      logic        stray;
   } cpl_exp_t;

   tx_exp_t  tx_q[$];
   cpl_exp_t cpl_q[$];
   tx_exp_t  mon_te;
   cpl_exp_t mon_ce;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int last_tx_cyc  = 0;
   int last_cpl_cyc = 0;
   bit allow_cpl  = 1'b1;

   // Reference model: slot ownership, round-robin pointer, pending requests.
   bit          m_valid [MO];
   int          m_owner [MO];
   int          m_rr;
   bit          p_valid [NR];
   bit          p_read  [NR];
   logic [2:0]  p_type  [NR];
   logic [63:0] p_addr  [NR];
   logic [31:0] p_data  [NR];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic stop_now(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "bench stopped early");
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req();
      for (int i = 0; i < NR; i++) begin
         bus.req_valid[i]          = p_valid[i];
         bus.req_is_read[i]        = p_read[i];
         bus.req_type[3*i +: 3]    = p_type[i];
         bus.req_addr[64*i +: 64]  = p_addr[i];
         bus.req_data[32*i +: 32]  = p_data[i];
      end
   endtask

   task automatic set_req(input int i, input bit rd, input logic [2:0] typ,
                          input logic [63:0] addr, input logic [31:0] data);
      p_valid[i] = 1'b1;
      p_read[i]  = rd;
      p_type[i]  = typ;
      p_addr[i]  = addr;
      p_data[i]  = data;
   endtask

   task automatic model_reset();
      for (int i = 0; i < MO; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < NR; i++) p_valid[i] = 1'b0;
      m_rr = 0;
   endtask

   function automatic int model_grant();
      int nfree;
      nfree = 0;
      for (int i = 0; i < MO; i++) if (!m_valid[i]) nfree++;
      for (int k = 0; k < NR; k++) begin
         int idx;
         idx = (m_rr + k) % NR;
         if (p_valid[idx] && (!p_read[idx] || nfree > 0)) return idx;
      end
      return -1;
   endfunction

   function automatic int lowest_free();
      for (int i = 0; i < MO; i++) if (!m_valid[i]) return i;
      return -1;
   endfunction

   function automatic int random_valid_slot();
      int vs[$];
      for (int i = 0; i < MO; i++) if (m_valid[i]) vs.push_back(i);
      if (vs.size() == 0) return -1;
      return vs[$urandom_range(0, vs.size() - 1)];
   endfunction

   // Decoder result for one cycle; expected outcome decided by the model.
   task automatic complete_tag(input int tag, input bit bad, input logic [31:0] data);
      cpl_exp_t e;
      e.data = data;
      e.err  = bad;
      if (tag < MO && m_valid[tag]) begin
         e.who   = m_owner[tag];
         e.stray = 1'b0;
         m_valid[tag] = 1'b0;
      end else begin
         e.who   = 0;
         e.stray = 1'b1;
      end
      cpl_q.push_back(e);
      bus.rx_tag  = 8'(tag);
      bus.rx_data = data;
      bus.rx_good = !bad;
      bus.rx_bad  = bad;
      step();
      bus.rx_good = 1'b0;
      bus.rx_bad  = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < MO; i++) begin
         if (m_valid[i]) complete_tag(i, 1'($urandom_range(0, 1)), $urandom);
      end
      repeat (2) step();
   endtask

   // Predict the grant of requester g, then wait for the encoder start.
   task automatic grant_and_start(input int g, output tx_exp_t e);
      int n;
      e.who  = g;
      e.typ  = p_type[g];
      e.addr = p_addr[g];
      e.data = p_data[g];
      if (p_read[g]) begin
         e.tag = 8'(lowest_free());
         m_valid[lowest_free()] = 1'b1;
         m_owner[e.tag] = g;
      end else begin
         e.tag = 8'hFF;
      end
      m_rr = (g + 1) % NR;
      tx_q.push_back(e);
      for (n = 0; n < 40; n++) begin
         step();
         if (bus.tx_start) break;
      end
      if (n == 40) stop_now("tx_start_wait");
   endtask

   task automatic run_pending(input int forced_tag);
      tx_exp_t e;
      int      g;
      int      t;
      while (model_grant() >= 0 || p_valid[0] || p_valid[1] || p_valid[2]) begin
         g = model_grant();
         if (g < 0) begin
            repeat (5) step();
            t = (forced_tag >= 0) ? forced_tag : random_valid_slot();
            complete_tag(t, 1'($urandom_range(0, 1)), $urandom);
            continue;
         end
         grant_and_start(g, e);
         p_valid[g] = 1'b0;
         drive_req();
         bus.tx_done = 1'($urandom_range(0, 1));
         step();
         bus.tx_done = 1'b0;
         check("busy_in_wait", bus.busy, 1);
         if (allow_cpl && $urandom_range(0, 2) == 0) begin
            t = ($urandom_range(0, 7) == 0) ? $urandom_range(MO, 255) : random_valid_slot();
            if (t >= 0) complete_tag(t, 1'($urandom_range(0, 1)), $urandom);
         end
         repeat ($urandom_range(0, 2)) step();
         check("tx_addr_hold", bus.tx_addr, e.addr);
         check("tx_tag_hold", bus.tx_tag, e.tag);
         bus.tx_done = 1'b1;
         step();
         bus.tx_done = 1'b0;
      end
   endtask

   // Monitor: every encoder start or completion output pops one expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.tx_start || bus.req_ready != '0) begin
            if (tx_q.size() == 0) begin
               check("unexpected_tx", {bus.tx_start, bus.req_ready}, 0);
            end else begin
               mon_te = tx_q.pop_front();
               last_tx_cyc = cyc;
               check("req_ready", bus.req_ready, 1 << mon_te.who);
               check("tx_start", bus.tx_start, 1);
               check("tx_type", bus.tx_type, mon_te.typ);
               check("tx_tag", bus.tx_tag, mon_te.tag);
               check("tx_addr", bus.tx_addr, mon_te.addr);
               check("tx_data", bus.tx_data, mon_te.data);
            end
         end
         if (bus.cpl_valid != '0 || bus.stray_cpl) begin
            if (cpl_q.size() == 0) begin
               check("unexpected_cpl", {bus.stray_cpl, bus.cpl_valid}, 0);
            end else begin
               mon_ce = cpl_q.pop_front();
               last_cpl_cyc = cyc;
               check("stray_cpl", bus.stray_cpl, mon_ce.stray);
               check("cpl_valid", bus.cpl_valid, mon_ce.stray ? 0 : (1 << mon_ce.who));
               if (!mon_ce.stray) begin
                  check("cpl_data", bus.cpl_data, mon_ce.data);
                  check("cpl_err", bus.cpl_err, mon_ce.err);
               end
            end
         end
      end
   end

   initial begin
      tx_exp_t e;
      int      k;
      bus.req_valid = '0;
      bus.req_is_read = '0;
      bus.req_type = '0;
      bus.req_addr = '0;
      bus.req_data = '0;
      bus.tx_done = 1'b0;
      bus.rx_tag = 8'd0;
      bus.rx_data = 32'd0;
      bus.rx_good = 1'b0;
      bus.rx_bad = 1'b0;
      model_reset();
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, 3'd0, 64'd0, 32'd0);
      for (int i = 0; i < NR; i++) p_valid[i] = 1'b0;
      repeat (3) step();
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_tx_start", bus.tx_start, 0);
      check("rst_tx_tag", bus.tx_tag, 0);
      check("rst_tx_addr", bus.tx_addr, 0);
      check("rst_cpl_valid", bus.cpl_valid, 0);
      check("rst_stray", bus.stray_cpl, 0);
      check("rst_busy", bus.busy, 0);
      rst_n = 1'b1;
      step();

      // Single write from requester 0.
      set_req(0, 1'b0, 3'd2, 64'h0000_0000_1000_0010, 32'hDEADBEEF);
      drive_req();
      run_pending(-1);
      step();
      check("idle_after_write", bus.busy, 0);

      // Reset while a read is being sent; its tag becomes stray.
      set_req(0, 1'b1, 3'd0, 64'h0000_0000_2000_0000, 32'd0);
      drive_req();
      grant_and_start(0, e);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      drive_req();
      step();
      step();
      rst_n = 1'b1;
      check("busy_after_reset", bus.busy, 0);
      step();
      complete_tag(int'(e.tag), 1'b0, 32'h0BAD_0BAD);
      repeat (2) step();

      // Requesters 0 and 1 together, twice: grants alternate.
      for (int r = 0; r < 2; r++) begin
         set_req(0, 1'b0, 3'd1, 64'h100 + 64'(r), 32'hA000_0000 + 32'(r));
         set_req(1, 1'b0, 3'd3, 64'h200 + 64'(r), 32'hB000_0000 + 32'(r));
         drive_req();
         run_pending(-1);
      end

      // Requester 1 read gets tag 0, then a good completion routed to it.
      allow_cpl = 1'b0;
      set_req(1, 1'b1, 3'd0, 64'h0000_0001_0000_0040, 32'd0);
      drive_req();
      run_pending(-1);
      complete_tag(0, 1'b0, 32'h12345678);
      repeat (2) step();

      // Five reads with four slots: fifth stalls until tag 2 returns.
      for (int r = 0; r < 5; r++) begin
         set_req(0, 1'b1, 3'd0, 64'h3000 + 64'(r * 4), 32'd0);
         drive_req();
         run_pending(2);
      end
      drain();

      // Completion with no slots in use.
      complete_tag(7, 1'b0, 32'h7777_7777);
      repeat (2) step();

`ifdef USER_TX_ARB_TIMEOUT_EN
      // Read never completed: timeout completion after CPL_TIMEOUT cycles.
      set_req(2, 1'b1, 3'd0, 64'h4000, 32'd0);
      drive_req();
      run_pending(-1);
      begin
         cpl_exp_t ce;
         ce.who = 2; ce.data = 32'd0; ce.err = 1'b1; ce.stray = 1'b0;
         cpl_q.push_back(ce);
         m_valid[e.tag] = 1'b0;
         for (int i = 0; i < MO; i++) m_valid[i] = 1'b0;
      end
      for (k = 0; k < 3 * CT; k++) begin
         step();
         if (cpl_q.size() == 0) break;
      end
      if (k == 3 * CT) stop_now("timeout_wait");
      check("timeout_latency", last_cpl_cyc - last_tx_cyc, CT + 1);
      step();
      check("timeout_slot_freed", bus.busy, 0);
`endif

      // Randomized traffic.
      allow_cpl = 1'b1;
      for (int it = 0; it < 25; it++) begin
         for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 1) == 1 || i == it % NR) begin
               set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       {$urandom, $urandom}, $urandom);
            end
         end
         drive_req();
         run_pending(-1);
`ifdef USER_TX_ARB_TIMEOUT_EN
         drain();
`endif
      end
      drain();
      repeat (3) step();
      check("idle_at_end", bus.busy, 0);
      check("tx_queue_empty", tx_q.size(), 0);
      check("cpl_queue_empty", cpl_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
